// File: rtl/l2_pkg.sv
// Shared types and constants for the L2 tag/control slice: FSM states,
// request operation type and the address geometry.
package l2_pkg;

   localparam int TAG_W = 18;
   localparam int IDX_W = 8;
   localparam int WAYS  = 2;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOOKUP = 3'd1,
      S_EVICT  = 3'd2,
      S_FILL   = 3'd3,
      S_RESP   = 3'd4,
      S_GUARD  = 3'd5
   } state_t;

   typedef enum logic {
      OP_RD = 1'b0,
      OP_WR = 1'b1
   } op_t;

endpackage

// File: rtl/l2_tag_array.sv
// Tag, valid, dirty and LRU state for a 2-way L2. Combinational lookup
// against the addressed set; one synchronous update per cycle on that set.
module l2_tag_array #(
   parameter int TAG_W = 18,
   parameter int IDX_W = 8
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic [IDX_W-1:0] idx,
   input  logic [TAG_W-1:0] tag,
   output logic             hit,
   output logic             hit_way,
   output logic             victim_way,
   output logic             victim_dirty,
   input  logic             rd_way,
   output logic [TAG_W-1:0] rd_tag,
   input  logic             upd_en,
   input  logic             upd_way,
   input  logic             upd_install,
   input  logic             upd_dirty,
   input  logic             upd_mark_dirty
);

   localparam int SETS = 1 << IDX_W;

   logic [TAG_W-1:0] tag_mem   [2][SETS];
   logic [1:0]       valid_mem [SETS];
   logic [1:0]       dirty_mem [SETS];
   logic [SETS-1:0]  lru_mem;
   logic             match0, match1;

   always_comb begin
      match0       = valid_mem[idx][0] && (tag_mem[0][idx] == tag);
      match1       = valid_mem[idx][1] && (tag_mem[1][idx] == tag);
      hit          = match0 || match1;
      hit_way      = !match0;
      // Invalid ways are filled first (way0 preferred) before LRU is consulted.
      if (!valid_mem[idx][0])      victim_way = 1'b0;
      else if (!valid_mem[idx][1]) victim_way = 1'b1;
      else                         victim_way = lru_mem[idx];
      victim_dirty = valid_mem[idx][victim_way] && dirty_mem[idx][victim_way];
      rd_tag       = tag_mem[rd_way][idx];
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         for (int s = 0; s < SETS; s++) begin
            tag_mem[0][s] <= '0;
            tag_mem[1][s] <= '0;
            valid_mem[s]  <= '0;
            dirty_mem[s]  <= '0;
         end
         lru_mem <= '0;
      end else begin
         if (upd_en) lru_mem[idx] <= ~upd_way;
         if (upd_install) begin
            tag_mem[upd_way][idx]   <= tag;
            valid_mem[idx][upd_way] <= 1'b1;
            dirty_mem[idx][upd_way] <= upd_dirty;
         end else if (upd_mark_dirty) begin
            dirty_mem[idx][upd_way] <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/l2_controller.sv
// L2 responder for L1-D line reads and dirty write-backs, with evict/refill
// toward memory. Define L2_PERF_CNT_EN to build the hit/miss counters.
module l2_controller
   import l2_pkg::*;
#(
   parameter int TAG_W = l2_pkg::TAG_W,
   parameter int IDX_W = l2_pkg::IDX_W,
   parameter int WAYS  = l2_pkg::WAYS
) (
   input  logic                   clk,
   input  logic                   nrst,
   input  logic                   read_L1_L2,
   input  logic                   write_L1_L2,
   input  logic [TAG_W-1:0]       tag_L1_L2,
   input  logic [IDX_W-1:0]       index_L1_L2,
   input  logic [TAG_W-1:0]       write_tag_L1_L2,
   input  logic [IDX_W-1:0]       write_index_L1_L2,
   output logic                   ready_L2_L1,
   output logic                   arr_way,
   output logic [IDX_W-1:0]       arr_index,
   output logic                   arr_rd,
   output logic                   arr_wr,
   output logic                   arr_fill,
   output logic                   read_L2_M,
   output logic                   write_L2_M,
   output logic [TAG_W+IDX_W-1:0] addr_L2_M,
   input  logic                   ready_M_L2,
   output logic                   L2_miss_o,
   output logic [31:0]            hit_cnt,
   output logic [31:0]            miss_cnt
);

   // state    | meaning
   // S_IDLE   | wait for an L1 request, latch it
   // S_LOOKUP | tag compare; hit serviced, miss picks a victim
   // S_EVICT  | write dirty victim to memory
   // S_FILL   | read requested line from memory
   // S_RESP   | one-cycle ready to L1
   // S_GUARD  | ignore requests while L1 drops its level

   if (WAYS != 2) begin : g_ways_check
      $error("l2_controller supports only WAYS == 2");
   end

   state_t           state_q, state_d;
   op_t              op_q;
   logic [TAG_W-1:0] tag_q;
   logic [IDX_W-1:0] idx_q;
   logic             way_q;
   logic             latch_req, save_victim;

   logic             hit, hit_way, victim_way, victim_dirty;
   logic [TAG_W-1:0] rd_tag;
   logic             upd_en, upd_way, upd_install, upd_dirty, upd_mark_dirty;

   l2_tag_array #(.TAG_W(TAG_W), .IDX_W(IDX_W)) u_tags (
      .clk            (clk),
      .nrst           (nrst),
      .idx            (idx_q),
      .tag            (tag_q),
      .hit            (hit),
      .hit_way        (hit_way),
      .victim_way     (victim_way),
      .victim_dirty   (victim_dirty),
      .rd_way         (way_q),
      .rd_tag         (rd_tag),
      .upd_en         (upd_en),
      .upd_way        (upd_way),
      .upd_install    (upd_install),
      .upd_dirty      (upd_dirty),
      .upd_mark_dirty (upd_mark_dirty)
   );

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q <= S_IDLE;
         op_q    <= OP_RD;
         tag_q   <= '0;
         idx_q   <= '0;
         way_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (latch_req) begin
            op_q  <= write_L1_L2 ? OP_WR : OP_RD;
            tag_q <= write_L1_L2 ? write_tag_L1_L2 : tag_L1_L2;
            idx_q <= write_L1_L2 ? write_index_L1_L2 : index_L1_L2;
         end
         if (save_victim) way_q <= victim_way;
      end
   end

   always_comb begin
      state_d        = state_q;
      latch_req      = 1'b0;
      save_victim    = 1'b0;
      ready_L2_L1    = 1'b0;
      arr_way        = way_q;
      arr_index      = idx_q;
      arr_rd         = 1'b0;
      arr_wr         = 1'b0;
      arr_fill       = 1'b0;
      read_L2_M      = 1'b0;
      write_L2_M     = 1'b0;
      addr_L2_M      = '0;
      L2_miss_o      = 1'b0;
      upd_en         = 1'b0;
      upd_way        = way_q;
      upd_install    = 1'b0;
      upd_dirty      = 1'b0;
      upd_mark_dirty = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (write_L1_L2 || read_L1_L2) begin
               latch_req = 1'b1;
               state_d   = S_LOOKUP;
            end
         end
         S_LOOKUP: begin
            if (hit) begin
               arr_way = hit_way;
               upd_en  = 1'b1;
               upd_way = hit_way;
               if (op_q == OP_WR) begin
                  arr_wr         = 1'b1;
                  upd_mark_dirty = 1'b1;
               end else begin
                  arr_rd = 1'b1;
               end
               state_d = S_RESP;
            end else begin
               L2_miss_o   = 1'b1;
               save_victim = 1'b1;
               arr_way     = victim_way;
               if (victim_dirty) begin
                  state_d = S_EVICT;
               end else if (op_q == OP_WR) begin
                  // Write-back carries the full line, so install without a fetch.
                  arr_wr      = 1'b1;
                  upd_en      = 1'b1;
                  upd_way     = victim_way;
                  upd_install = 1'b1;
                  upd_dirty   = 1'b1;
                  state_d     = S_RESP;
               end else begin
                  state_d = S_FILL;
               end
            end
         end
         S_EVICT: begin
            write_L2_M = 1'b1;
            addr_L2_M  = {rd_tag, idx_q};
            if (ready_M_L2) begin
               if (op_q == OP_WR) begin
                  arr_wr      = 1'b1;
                  upd_en      = 1'b1;
                  upd_install = 1'b1;
                  upd_dirty   = 1'b1;
                  state_d     = S_RESP;
               end else begin
                  state_d = S_FILL;
               end
            end
         end
         S_FILL: begin
            read_L2_M = 1'b1;
            addr_L2_M = {tag_q, idx_q};
            if (ready_M_L2) begin
               arr_fill    = 1'b1;
               upd_en      = 1'b1;
               upd_install = 1'b1;
               state_d     = S_LOOKUP;
            end
         end
         S_RESP: begin
            ready_L2_L1 = 1'b1;
            state_d     = S_GUARD;
         end
         S_GUARD: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

`ifdef L2_PERF_CNT_EN
   logic refill_q;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         refill_q <= 1'b0;
         hit_cnt  <= '0;
         miss_cnt <= '0;
      end else begin
         // Re-lookup after a fill always hits and is not a genuine hit.
         if (state_q == S_IDLE)                    refill_q <= 1'b0;
         else if (state_q == S_FILL && ready_M_L2) refill_q <= 1'b1;
         if (state_q == S_LOOKUP && hit && !refill_q) hit_cnt <= hit_cnt + 32'd1;
         if (L2_miss_o) miss_cnt <= miss_cnt + 32'd1;
      end
   end
`else
   assign hit_cnt  = '0;
   assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_l2_controller.sv
// Directed bench for l2_controller: cold miss, hit, write-back, dirty eviction,
// request priority and reset abort, with hand-computed expectations.
module tb_l2_controller;

   logic        clk = 1'b0;
   logic        nrst;
   logic        read_L1_L2, write_L1_L2;
   logic [17:0] tag_L1_L2, write_tag_L1_L2;
   logic [7:0]  index_L1_L2, write_index_L1_L2;
   logic        ready_L2_L1, arr_way, arr_rd, arr_wr, arr_fill;
   logic [7:0]  arr_index;
   logic        read_L2_M, write_L2_M, ready_M_L2, L2_miss_o;
   logic [25:0] addr_L2_M;
   logic [31:0] hit_cnt, miss_cnt;

   int errors = 0;
   int checks = 0;

`ifdef L2_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   l2_controller dut (
      .clk               (clk),
      .nrst              (nrst),
      .read_L1_L2        (read_L1_L2),
      .write_L1_L2       (write_L1_L2),
      .tag_L1_L2         (tag_L1_L2),
      .index_L1_L2       (index_L1_L2),
      .write_tag_L1_L2   (write_tag_L1_L2),
      .write_index_L1_L2 (write_index_L1_L2),
      .ready_L2_L1       (ready_L2_L1),
      .arr_way           (arr_way),
      .arr_index         (arr_index),
      .arr_rd            (arr_rd),
      .arr_wr            (arr_wr),
      .arr_fill          (arr_fill),
      .read_L2_M         (read_L2_M),
      .write_L2_M        (write_L2_M),
      .addr_L2_M         (addr_L2_M),
      .ready_M_L2        (ready_M_L2),
      .L2_miss_o         (L2_miss_o),
      .hit_cnt           (hit_cnt),
      .miss_cnt          (miss_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", name, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic logic [31:0] cnt(input logic [31:0] n);
      return PERF ? n : 32'd0;
   endfunction

   initial begin
      nrst = 1'b0;
      read_L1_L2 = 0; write_L1_L2 = 0; ready_M_L2 = 0;
      tag_L1_L2 = '0; index_L1_L2 = '0; write_tag_L1_L2 = '0; write_index_L1_L2 = '0;
      cyc(); cyc();
      chk("rst_outputs", {ready_L2_L1, arr_way, arr_rd, arr_wr, arr_fill, read_L2_M, write_L2_M, L2_miss_o}, 0);
      chk("rst_addr", 32'(addr_L2_M), 0);
      chk("rst_idx", 32'(arr_index), 0);
      chk("rst_hitcnt", hit_cnt, 0);
      nrst = 1'b1;
      cyc();

      // Cold read tag 0x12 idx 0x05
      read_L1_L2 = 1; tag_L1_L2 = 18'h00012; index_L1_L2 = 8'h05;
      cyc();
      chk("cold_miss", 32'(L2_miss_o), 1);
      chk("cold_no_rd", 32'(arr_rd), 0);
      cyc();
      chk("cold_rdm", 32'(read_L2_M), 1);
      chk("cold_addr", 32'(addr_L2_M), 32'h0001205);
      cyc();
      chk("cold_rdm_hold", 32'(read_L2_M), 1);
      ready_M_L2 = 1; #1;
      chk("cold_fill", 32'({arr_fill, arr_way}), 32'b10);
      @(negedge clk); ready_M_L2 = 0;
      chk("cold_relookup_rd", 32'({arr_rd, L2_miss_o, ready_L2_L1}), 32'b100);
      cyc();
      chk("cold_ready", 32'(ready_L2_L1), 1);
      cyc();
      chk("cold_guard", 32'(ready_L2_L1), 0);
      read_L1_L2 = 0;
      cyc();

      // Memory ready while idle is ignored
      ready_M_L2 = 1; #1;
      chk("idle_mready", 32'({arr_fill, arr_wr, read_L2_M}), 0);
      @(negedge clk); ready_M_L2 = 0;

      // Repeat read: hit, ready two cycles after sampling
      read_L1_L2 = 1;
      cyc();
      chk("hit_rd", 32'({arr_rd, L2_miss_o, arr_way}), 32'b100);
      cyc();
      chk("hit_ready", 32'(ready_L2_L1), 1);
      chk("hit_cnt1", hit_cnt, cnt(1));
      chk("miss_cnt1", miss_cnt, cnt(1));
      cyc(); read_L1_L2 = 0;
      cyc();

      // Write-back hit to tag 0x12 idx 0x05
      write_L1_L2 = 1; write_tag_L1_L2 = 18'h00012; write_index_L1_L2 = 8'h05;
      cyc();
      chk("wb_hit", 32'({arr_wr, arr_way, L2_miss_o, write_L2_M, read_L2_M}), 32'b10000);
      cyc();
      chk("wb_ready", 32'({ready_L2_L1, write_L2_M, read_L2_M}), 32'b100);
      cyc(); write_L1_L2 = 0;
      cyc();

      // Fill way1 with tag 0x34
      read_L1_L2 = 1; tag_L1_L2 = 18'h00034;
      cyc();
      chk("w1_miss", 32'(L2_miss_o), 1);
      cyc();
      chk("w1_addr", 32'(addr_L2_M), 32'h0003405);
      ready_M_L2 = 1; #1;
      chk("w1_fill_way", 32'({arr_fill, arr_way}), 32'b11);
      @(negedge clk); ready_M_L2 = 0;
      chk("w1_relookup", 32'({arr_rd, arr_way}), 32'b11);
      cyc();
      chk("w1_ready", 32'(ready_L2_L1), 1);
      cyc(); read_L1_L2 = 0;
      cyc();

      // Third tag 0x56: LRU victim way0 (dirty, tag 0x12) is evicted first
      read_L1_L2 = 1; tag_L1_L2 = 18'h00056;
      cyc();
      chk("ev_miss", 32'(L2_miss_o), 1);
      cyc();
      chk("ev_wrm", 32'({write_L2_M, read_L2_M, arr_way}), 32'b100);
      chk("ev_addr", 32'(addr_L2_M), 32'h0001205);
      cyc();
      chk("ev_wait", 32'(write_L2_M), 1);
      ready_M_L2 = 1;
      @(negedge clk); ready_M_L2 = 0;
      chk("ev_fill_rdm", 32'({read_L2_M, write_L2_M}), 32'b10);
      chk("ev_fill_addr", 32'(addr_L2_M), 32'h0005605);
      ready_M_L2 = 1; #1;
      chk("ev_fill", 32'({arr_fill, arr_way}), 32'b10);
      @(negedge clk); ready_M_L2 = 0;
      chk("ev_relookup", 32'(arr_rd), 1);
      cyc();
      chk("ev_ready", 32'(ready_L2_L1), 1);
      chk("miss_cnt3", miss_cnt, cnt(3));
      cyc(); read_L1_L2 = 0;
      cyc();

      // Simultaneous read (0x34 idx5) and write (0x77 idx9): write first
      read_L1_L2 = 1; tag_L1_L2 = 18'h00034;
      write_L1_L2 = 1; write_tag_L1_L2 = 18'h00077; write_index_L1_L2 = 8'h09;
      cyc();
      chk("pri_wr_install", 32'({L2_miss_o, arr_wr, arr_rd, arr_way}), 32'b1100);
      chk("pri_idx", 32'(arr_index), 32'h09);
      cyc();
      chk("pri_ready", 32'(ready_L2_L1), 1);
      cyc();
      chk("pri_guard", 32'({ready_L2_L1, arr_wr, arr_rd, L2_miss_o}), 0);
      write_L1_L2 = 0;
      cyc();
      cyc();
      chk("pri_rd_next", 32'({arr_rd, arr_wr, arr_way, L2_miss_o}), 32'b1010);
      chk("pri_rd_idx", 32'(arr_index), 32'h05);
      cyc();
      chk("pri_rd_ready", 32'(ready_L2_L1), 1);
      chk("hit_cnt3", hit_cnt, cnt(3));
      chk("miss_cnt4", miss_cnt, cnt(4));
      cyc(); read_L1_L2 = 0;
      cyc();

      // Reset during S_FILL
      read_L1_L2 = 1; tag_L1_L2 = 18'h00099; index_L1_L2 = 8'h20;
      cyc();
      cyc();
      chk("rf_rdm", 32'(read_L2_M), 1);
      #2 nrst = 1'b0; #1;
      chk("rf_abort", 32'({read_L2_M, write_L2_M, ready_L2_L1, arr_fill, arr_rd, arr_wr}), 0);
      chk("rf_addr", 32'(addr_L2_M), 0);
      chk("rf_idx", 32'(arr_index), 0);
      chk("rf_cnt", miss_cnt, 0);
      read_L1_L2 = 0;
      @(negedge clk); cyc();
      nrst = 1'b1;
      cyc();
      read_L1_L2 = 1;
      cyc();
      chk("rf_remiss", 32'(L2_miss_o), 1);
      cyc();
      chk("rf_refill_addr", 32'(addr_L2_M), 32'h0009920);
      ready_M_L2 = 1;
      @(negedge clk); ready_M_L2 = 0;
      cyc();
      chk("rf_ready", 32'(ready_L2_L1), 1);
      chk("rf_miss_cnt", miss_cnt, cnt(1));
      cyc(); read_L1_L2 = 0;
      cyc();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
